reduct_collect: RTL and testbench
=================================

# reduct_collect

Serial front end for the `reduct` reduction tree. It accepts one DATA-wide word per cycle over a valid/ready handshake and collects IN words into a packed buffer. It then drives that buffer into an internal `reduct` instance and holds the registered result until a downstream consumer takes it. It converts a word stream into one reduced word per group.

## Interface
- OPE, "or", reduction operation: "and", "or" or "xor".
- NOT, `DISABLE, invert the reduced result when `ENABLE.
- IN, 4, words per group (≥2).
- DATA, 16, word width.
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  DATA  input word.
- flush  input  1  close the current partial group. Present only with REDUCT_COLLECT_FLUSH_EN.
- out_valid  output  1  out_data/out_cnt are valid.
- out_ready  input  1  consumer takes the result.
- out_data  output  DATA  reduced result.
- out_cnt  output  $clog2(IN+1)  number of words in the group (1..IN).

## Operation
- States: COLLECT, REDUCE, OUTPUT.
- COLLECT:
  - in_ready=1.
  - On in_valid&&in_ready: buf[cnt]←in_data, cnt←cnt+1.
  - Accepting the word at cnt==IN-1 → REDUCE.
- REDUCE (1 cycle):
  - in_ready=0.
  - out_data←reduct(buf), out_cnt←cnt, then → OUTPUT.
- OUTPUT:
  - out_valid=1. out_data and out_cnt are held stable and in_ready=0.
  - On out_ready: → COLLECT, cnt←0, every buf slot←identity.
- Identity fill: all-ones for "and", zero for "or"/"xor".
  - Unfilled slots always hold the identity.
  - NOT applies after the reduction, so partial groups follow the same rule.
- buf[0] holds the first accepted word. Slot order does not affect the result.
- Unsupported OPE values produce out_data=0.
- Reset mid-operation:
  - The partial group is discarded and state → COLLECT.
  - Any result in REDUCE or OUTPUT is lost.

## Timing
- Reset values: in_ready=1 (state COLLECT), out_valid=0, out_data=0, out_cnt=0, cnt=0, buf=identity.
- Latency: last word accepted in cycle t → out_valid=1 in cycle t+2.
- out_ready in cycle u with out_valid=1 → out_valid=0 and in_ready=1 in cycle u+1. There is no same-cycle bypass.
- Minimum group period: IN+2 cycles.
- Inputs arriving while in_ready=0 are ignored. The upstream side must hold in_valid and in_data.
- out_ready while out_valid=0 is ignored.

## Configuration
- REDUCT_COLLECT_FLUSH_EN defined:
  - The flush port exists. It is sampled only in COLLECT.
  - flush=1 with cnt>0, or with a word accepted in the same cycle, → REDUCE. A word accepted in that cycle is included.
  - flush=1 with cnt==0 and no accepted word is ignored.
  - flush in REDUCE or OUTPUT is ignored.
- REDUCT_COLLECT_FLUSH_EN undefined:
  - The flush port is absent.
  - Groups are always exactly IN words and out_cnt is always IN.

## Structure
- Shared package reduct_pkg:
  - state enum typedef (COLLECT/REDUCE/OUTPUT).
  - identity-value function of OPE and DATA.
  - cnt width localparam.
- One sub-module: `reduct`. Its OPE, NOT and DATA parameters are forwarded and its input is buf.
- The controller FSM, counter and buffer stay in reduct_collect.

## Test plan
- OPE "or", IN 4: feed 0x0001, 0x0002, 0x0004, 0x0008 back-to-back → out_data=0x000F, out_cnt=4, out_valid two cycles after the 4th accept.
- OPE "xor": feed 0xFFFF, 0x00FF, 0x0F0F, 0x3333 → out_data=0xC33C.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → out_data stable, in_ready=0 throughout. Raise out_ready → in_ready=1 on the next cycle.
- Reset mid-group: feed 0xAAAA, 0x5555, assert reset, then feed "or" group 0x0010, 0x0020, 0x0040, 0x0080 → out_data=0x00F0.
- FLUSH_EN, OPE "and": feed 0xF0F0, then 0xFF00 with flush in the same cycle → out_data=0xF000, out_cnt=2. A flush pulse with an empty buffer produces no out_valid.
- NOT=`ENABLE, OPE "or": feed 0x0001, 0x0002, 0x0000, 0x0000 → out_data=0xFFFC. Repeat with 100 random groups checked against a software model.

Source files
------------

// File: rtl/reduct_pkg.sv
// Shared types and helpers for the reduct tree and its serial collector front end.
// ENABLE/DISABLE are the on/off values used for the NOT parameter.
`ifndef ENABLE
`define ENABLE 1'b1
`endif
`ifndef DISABLE
`define DISABLE 1'b0
`endif

package reduct_pkg;
   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      REDUCE  = 2'd1,
      OUTPUT  = 2'd2
   } state_t;

   localparam int MAX_DATA = 1024;
   localparam int IN_DEFAULT = 4;
   localparam int CNT_W_DEFAULT = $clog2(IN_DEFAULT + 1);

   // Counter must reach IN itself, so it needs one extra code beyond IN-1.
   function automatic int cnt_w(input int in);
      return $clog2(in + 1);
   endfunction

   function automatic logic [MAX_DATA-1:0] identity(input string ope, input int data);
      logic [MAX_DATA-1:0] v;
      v = '0;
      if (ope == "and") begin
         for (int i = 0; i < MAX_DATA; i++) begin
            if (i < data) v[i] = 1'b1;
         end
      end
      return v;
   endfunction

   function automatic bit ope_ok(input string ope);
      return (ope == "and") || (ope == "or") || (ope == "xor");
   endfunction
endpackage

// File: rtl/reduct_collect_if.sv
// Word-in / result-out handshake bundle for reduct_collect.
// The flush signal exists only when REDUCT_COLLECT_FLUSH_EN is defined.
interface reduct_collect_if
   import reduct_pkg::*;
#(
   parameter int IN   = 4,
   parameter int DATA = 16
);
   logic                   in_valid;
   logic                   in_ready;
   logic [DATA-1:0]        in_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [DATA-1:0]        out_data;
   logic [cnt_w(IN)-1:0]   out_cnt;
`ifdef REDUCT_COLLECT_FLUSH_EN
   logic                   flush;
`endif

   modport slave (
`ifdef REDUCT_COLLECT_FLUSH_EN
      input  flush,
`endif
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_cnt
   );

   modport master (
`ifdef REDUCT_COLLECT_FLUSH_EN
      output flush,
`endif
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_cnt
   );
endinterface

// File: rtl/reduct.sv
// Combinational and/or/xor reduction of IN packed DATA-wide words with optional inversion.
// Unsupported operations reduce to zero regardless of NOT.
module reduct
   import reduct_pkg::*;
#(
   parameter string OPE  = "or",
   parameter bit    NOT  = `DISABLE,
   parameter int    IN   = 4,
   parameter int    DATA = 16
) (
   input  logic [IN*DATA-1:0] words,
   output logic [DATA-1:0]    result
);
   localparam logic [DATA-1:0] ID     = DATA'(identity(OPE, DATA));
   localparam bit              IS_AND = (OPE == "and");
   localparam bit              IS_OR  = (OPE == "or");
   localparam bit              IS_XOR = (OPE == "xor");
   localparam bit              OK     = ope_ok(OPE);

   logic [DATA-1:0] acc;

   always_comb begin
      acc = ID;
      for (int i = 0; i < IN; i++) begin
         if (IS_AND)      acc = acc & words[i*DATA +: DATA];
         else if (IS_OR)  acc = acc | words[i*DATA +: DATA];
         else if (IS_XOR) acc = acc ^ words[i*DATA +: DATA];
      end
      if (!OK)      result = '0;
      else if (NOT) result = ~acc;
      else          result = acc;
   end
endmodule

// File: rtl/reduct_collect.sv
// Collects up to IN words into a buffer, reduces them with reduct and holds the result
// until taken. Optional early group close via flush under REDUCT_COLLECT_FLUSH_EN.
module reduct_collect
   import reduct_pkg::*;
#(
   parameter string OPE  = "or",
   parameter bit    NOT  = `DISABLE,
   parameter int    IN   = 4,
   parameter int    DATA = 16
) (
   input  logic          clk,
   input  logic          reset,
   reduct_collect_if.slave bus
);
   localparam int              CW = cnt_w(IN);
   localparam logic [DATA-1:0] ID = DATA'(identity(OPE, DATA));

   state_t            state, state_next;
   logic [CW-1:0]     cnt;
   logic [DATA-1:0]   words_p0 [IN];
   logic [IN*DATA-1:0] flat_p0;
   logic [DATA-1:0]   reduced;
   logic [DATA-1:0]   out_data_p1;
   logic [CW-1:0]     out_cnt_p1;
   logic              in_rdy;
   logic              out_vld;
   logic              accept;
   logic              close;

   assign accept = bus.in_valid && in_rdy;

   // A flush closes the group only if it would contain at least one word.
`ifdef REDUCT_COLLECT_FLUSH_EN
   assign close = (state == COLLECT) &&
                  ((accept && cnt == CW'(IN - 1)) || (bus.flush && (cnt != '0 || accept)));
`else
   assign close = (state == COLLECT) && accept && cnt == CW'(IN - 1);
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= COLLECT;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         COLLECT: if (close) state_next = REDUCE;
         REDUCE:  state_next = OUTPUT;
         OUTPUT:  if (bus.out_ready) state_next = COLLECT;
         default: state_next = COLLECT;
      endcase
   end

   always_comb begin
      in_rdy  = (state == COLLECT);
      out_vld = (state == OUTPUT);
   end

   always_comb begin
      for (int i = 0; i < IN; i++) flat_p0[i*DATA +: DATA] = words_p0[i];
   end

   reduct #(
      .OPE  (OPE),
      .NOT  (NOT),
      .IN   (IN),
      .DATA (DATA)
   ) u_reduct (
      .words  (flat_p0),
      .result (reduced)
   );

   // collect stage -> result register
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt         <= '0;
         out_data_p1 <= '0;
         out_cnt_p1  <= '0;
         for (int i = 0; i < IN; i++) words_p0[i] <= ID;
      end else begin
         case (state)
            COLLECT: begin
               if (accept) begin
                  for (int i = 0; i < IN; i++) begin
                     if (cnt == CW'(i)) words_p0[i] <= bus.in_data;
                  end
                  cnt <= cnt + CW'(1);
               end
            end
            REDUCE: begin
               out_data_p1 <= reduced;
               out_cnt_p1  <= cnt;
            end
            OUTPUT: begin
               if (bus.out_ready) begin
                  cnt <= '0;
                  for (int i = 0; i < IN; i++) words_p0[i] <= ID;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = out_vld;
   assign bus.out_data  = out_data_p1;
   assign bus.out_cnt   = out_cnt_p1;
endmodule

// File: tb/tb_reduct_collect.sv
// Four collectors (or, xor, and, or+NOT) share one stimulus stream and are checked each
// cycle against a queue-based group model, plus directed literal expectations.
module tb_reduct_collect;
   import reduct_pkg::*;

   localparam int IN   = 4;
   localparam int DATA = 16;
   localparam int CW   = cnt_w(IN);
   localparam int NDUT = 4;
`ifdef REDUCT_COLLECT_FLUSH_EN
   localparam bit FLUSH = 1'b1;
`else
   localparam bit FLUSH = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid;
   logic [DATA-1:0] in_data;
   logic            out_ready;
`ifdef REDUCT_COLLECT_FLUSH_EN
   logic            flush;
`endif

   logic [NDUT-1:0] rdy;
   logic [NDUT-1:0] vld;
   logic [DATA-1:0] dat [NDUT];
   logic [CW-1:0]   cnt [NDUT];

   int checks = 0;
   int errors = 0;
   bit armed  = 1'b0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < NDUT; k++) begin : g_dut
      reduct_collect_if #(.IN(IN), .DATA(DATA)) bus ();
      assign bus.in_valid  = in_valid;
      assign bus.in_data   = in_data;
      assign bus.out_ready = out_ready;
`ifdef REDUCT_COLLECT_FLUSH_EN
      assign bus.flush     = flush;
`endif
      assign rdy[k] = bus.in_ready;
      assign vld[k] = bus.out_valid;
      assign dat[k] = bus.out_data;
      assign cnt[k] = bus.out_cnt;
      if (k == 0) begin : g_or
         reduct_collect #(.OPE("or"), .NOT(1'b0), .IN(IN), .DATA(DATA))
            dut (.clk(clk), .reset(reset), .bus(bus));
      end else if (k == 1) begin : g_xor
         reduct_collect #(.OPE("xor"), .NOT(1'b0), .IN(IN), .DATA(DATA))
            dut (.clk(clk), .reset(reset), .bus(bus));
      end else if (k == 2) begin : g_and
         reduct_collect #(.OPE("and"), .NOT(1'b0), .IN(IN), .DATA(DATA))
            dut (.clk(clk), .reset(reset), .bus(bus));
      end else begin : g_ornot
         reduct_collect #(.OPE("or"), .NOT(1'b1), .IN(IN), .DATA(DATA))
            dut (.clk(clk), .reset(reset), .bus(bus));
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: fold the group with plain operators, starting from the op's identity.
   function automatic logic [DATA-1:0] ref_reduce(input int k, input logic [DATA-1:0] g [$]);
      logic [DATA-1:0] a;
      a = (k == 2) ? '1 : '0;
      foreach (g[i]) begin
         case (k)
            1:       a = a ^ g[i];
            2:       a = a & g[i];
            default: a = a | g[i];
         endcase
      end
      if (k == 3) a = ~a;
      return a;
   endfunction

   bit              m_busy, m_pend, m_valid;
   int              m_cnt;
   logic [DATA-1:0] m_data [NDUT];
   logic [DATA-1:0] grp [$];

   always @(posedge clk) begin
      bit fl;
`ifdef REDUCT_COLLECT_FLUSH_EN
      fl = flush;
`else
      fl = 1'b0;
`endif
      if (reset) begin
         m_busy = 0; m_pend = 0; m_valid = 0; m_cnt = 0;
         grp.delete();
         for (int k = 0; k < NDUT; k++) m_data[k] = '0;
      end else if (!m_busy) begin
         if (in_valid) grp.push_back(in_data);
         if (grp.size() == IN || (FLUSH && fl && grp.size() > 0)) begin
            m_busy = 1; m_pend = 1;
         end
      end else if (m_pend) begin
         m_pend  = 0;
         m_valid = 1;
         m_cnt   = grp.size();
         for (int k = 0; k < NDUT; k++) m_data[k] = ref_reduce(k, grp);
      end else if (out_ready) begin
         m_valid = 0; m_busy = 0;
         grp.delete();
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("in_ready[%0d]", k), 32'(rdy[k]), 32'(!m_busy));
            chk($sformatf("out_valid[%0d]", k), 32'(vld[k]), 32'(m_valid));
            if (m_valid) begin
               chk($sformatf("out_data[%0d]", k), 32'(dat[k]), 32'(m_data[k]));
               chk($sformatf("out_cnt[%0d]", k), 32'(cnt[k]), 32'(m_cnt));
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DATA-1:0] d);
      bit r;
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      do begin
         r = rdy[0];
         step();
         n++;
      end while (!r && n < 50);
      if (!r) chk("send_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic wait_result();
      for (int i = 0; i < 50 && !vld[0]; i++) step();
      chk("wait_valid", 32'(vld[0]), 1);
   endtask

   task automatic consume();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      int groups, cycles;
      reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef REDUCT_COLLECT_FLUSH_EN
      flush = 1'b0;
`endif
      repeat (3) step();
      for (int k = 0; k < NDUT; k++) begin
         chk("rst_in_ready", 32'(rdy[k]), 1);
         chk("rst_out_valid", 32'(vld[k]), 0);
         chk("rst_out_data", 32'(dat[k]), 0);
         chk("rst_out_cnt", 32'(cnt[k]), 0);
      end
      reset = 1'b0;
      armed = 1'b1;

      // back-to-back group, latency, backpressure
      send(16'h0001); send(16'h0002); send(16'h0004); send(16'h0008);
      chk("lat_t1_valid", 32'(vld[0]), 0);
      step();
      chk("lat_t2_valid", 32'(vld[0]), 1);
      chk("or_data", 32'(dat[0]), 32'h000F);
      chk("or_cnt", 32'(cnt[0]), 4);
      chk("xor_data_a", 32'(dat[1]), 32'h000F);
      chk("and_data_a", 32'(dat[2]), 32'h0000);
      chk("ornot_data_a", 32'(dat[3]), 32'hFFF0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_data", 32'(dat[0]), 32'h000F);
         chk("bp_in_ready", 32'(rdy[0]), 0);
      end
      consume();
      chk("release_in_ready", 32'(rdy[0]), 1);
      chk("release_valid", 32'(vld[0]), 0);

      send(16'hFFFF); send(16'h00FF); send(16'h0F0F); send(16'h3333);
      wait_result();
      chk("xor_data", 32'(dat[1]), 32'hC33C);
      consume();

      send(16'h0001); send(16'h0002); send(16'h0000); send(16'h0000);
      wait_result();
      chk("ornot_data", 32'(dat[3]), 32'hFFFC);
      consume();

      // reset discards a partial group
      send(16'hAAAA); send(16'h5555);
      reset = 1'b1;
      step();
      reset = 1'b0;
      send(16'h0010); send(16'h0020); send(16'h0040); send(16'h0080);
      wait_result();
      chk("rst_group_data", 32'(dat[0]), 32'h00F0);
      consume();

`ifdef REDUCT_COLLECT_FLUSH_EN
      send(16'hF0F0);
      flush = 1'b1;
      send(16'hFF00);
      flush = 1'b0;
      wait_result();
      chk("flush_and_data", 32'(dat[2]), 32'hF000);
      chk("flush_and_cnt", 32'(cnt[2]), 2);
      consume();
      flush = 1'b1;
      step();
      flush = 1'b0;
      repeat (4) step();
      chk("empty_flush_valid", 32'(vld[0]), 0);
`endif

      groups = 0;
      cycles = 0;
      while (groups < 100 && cycles < 20000) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = DATA'($urandom);
         out_ready = ($urandom_range(0, 1) == 1);
`ifdef REDUCT_COLLECT_FLUSH_EN
         flush     = ($urandom_range(0, 9) == 0);
`endif
         if (vld[0] && out_ready) groups++;
         step();
         cycles++;
      end
      chk("random_groups_done", 32'(groups >= 100), 1);
      in_valid = 1'b0; out_ready = 1'b0;
`ifdef REDUCT_COLLECT_FLUSH_EN
      flush = 1'b0;
`endif
      step();
      armed = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
